// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 3-stage core pipeline controller:
//   NOP_INST     - instruction word a flushed pipe register loads
//   PC_RESET     - reset / flush address
//   pipe_state_e - pipe_ctrl FSM encodings (visible on state_o)
//   hold_src_e   - winning hold source after priority arbitration
//   hold_src()   - irq > ex > bus priority resolver
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_SPARE    = 2'd3
  } pipe_state_e;

  typedef enum logic [1:0] {
    HOLD_NONE = 2'd0,
    HOLD_BUS  = 2'd1,
    HOLD_EX   = 2'd2,
    HOLD_IRQ  = 2'd3
  } hold_src_e;

  // Only the highest-priority requester matters; lower ones are masked.
  function automatic hold_src_e hold_src(input logic irq, input logic ex, input logic bus);
    hold_src_e src;
    if (irq) begin
      src = HOLD_IRQ;
    end else if (ex) begin
      src = HOLD_EX;
    end else if (bus) begin
      src = HOLD_BUS;
    end else begin
      src = HOLD_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/gen_pipe_dff.sv
// -----------------------------------------------------------------------------
// gen_pipe_dff
// Generic enabled pipeline register with asynchronous active-low reset to a
// parameterised value.
//   clk   in  1  clock
//   rst_  in  1  asynchronous active-low reset (loads RST_VAL)
//   i_en  in  1  load enable
//   i_d   in  W  data in
//   o_q   out W  registered data
// -----------------------------------------------------------------------------
module gen_pipe_dff #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller for the 3-stage core. Arbitrates hold requests
// (irq > ex > bus), drives hold/flush for pc_reg, if_id and id_ex, and
// sequences branch/jump redirects including deferral across fetch-bus stalls.
//   clk             in   1            core clock
//   rst_            in   1            asynchronous active-low reset
//   jump_req_i      in   1            ex requests a redirect this cycle
//   jump_addr_i     in   ADDR_W       redirect target
//   hold_irq_req_i  in   1            interrupt controller freezes whole pipe
//   hold_ex_req_i   in   1            multi-cycle ex op busy
//   hold_bus_req_i  in   1            instruction fetch not ready
//   hold_pc_o       out  1            pc_reg keeps value
//   hold_if_id_o    out  1            if_id keeps value
//   hold_id_ex_o    out  1            id_ex keeps value
//   flush_if_id_o   out  1            if_id loads NOP/0 (beats hold_if_id_o)
//   flush_id_ex_o   out  1            id_ex loads NOP/0
//   pc_load_o       out  1            pc_reg loads pc_load_addr_o
//   pc_load_addr_o  out  ADDR_W       redirect target
//   state_o         out  2            FSM state (debug)
//   stall_cnt_o     out  STALL_CNT_W  saturating count of hold_pc_o cycles
// All control outputs are combinational from inputs and current state.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   jump_req_i,
  input  logic [ADDR_W-1:0]      jump_addr_i,
  input  logic                   hold_irq_req_i,
  input  logic                   hold_ex_req_i,
  input  logic                   hold_bus_req_i,
  output logic                   hold_pc_o,
  output logic                   hold_if_id_o,
  output logic                   hold_id_ex_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   pc_load_o,
  output logic [ADDR_W-1:0]      pc_load_addr_o,
  output logic [1:0]             state_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  // Counter preload after a PC load; the load cycle itself is the first
  // flush cycle, so FLUSH only has to cover the remaining ones.
  localparam logic [1:0]  FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam pipe_state_e LOAD_NEXT  = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  pipe_state_e            r_state;
  pipe_state_e            w_state_next;
  logic [1:0]             r_flush_cnt;
  logic [1:0]             w_flush_cnt_next;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [ADDR_W-1:0]      w_pend_addr;
  logic                   w_latch_en;
  hold_src_e              w_src;
  logic                   w_hold_all;
  logic                   w_hold_bus;
  logic                   w_jump_acc;

  assign w_src      = hold_src(hold_irq_req_i, hold_ex_req_i, hold_bus_req_i);
  assign w_hold_all = (w_src == HOLD_IRQ) || (w_src == HOLD_EX);
  assign w_hold_bus = (w_src == HOLD_BUS);
  // An irq/ex freeze drops the jump; ex re-issues it once released.
  assign w_jump_acc = jump_req_i && !w_hold_all;

  // Pending redirect target, captured when a jump meets a fetch-bus stall.
  gen_pipe_dff #(
    .W       (ADDR_W),
    .RST_VAL (ADDR_W'(PC_RESET))
  ) u_pend_addr (
    .clk  (clk),
    .rst_ (rst_),
    .i_en (w_latch_en),
    .i_d  (jump_addr_i),
    .o_q  (w_pend_addr)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_latch_en       = 1'b0;
    hold_pc_o        = 1'b0;
    hold_if_id_o     = 1'b0;
    hold_id_ex_o     = 1'b0;
    flush_if_id_o    = 1'b0;
    flush_id_ex_o    = 1'b0;
    pc_load_o        = 1'b0;
    pc_load_addr_o   = '0;

    // Hold arbitration. A bus stall lets ex drain, so id_ex gets a bubble.
    if (w_hold_all) begin
      hold_pc_o    = 1'b1;
      hold_if_id_o = 1'b1;
      hold_id_ex_o = 1'b1;
    end else if (w_hold_bus) begin
      hold_pc_o     = 1'b1;
      hold_if_id_o  = 1'b1;
      flush_id_ex_o = 1'b1;
    end

    case (r_state)
      ST_RUN: begin
        pc_load_addr_o = jump_addr_i;
      end
      ST_REDIRECT: begin
        pc_load_addr_o = w_pend_addr;
        flush_if_id_o  = 1'b1;
        if (!w_hold_all && !w_hold_bus) begin
          pc_load_o        = 1'b1;
          flush_id_ex_o    = 1'b1;
          w_state_next     = LOAD_NEXT;
          w_flush_cnt_next = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        flush_if_id_o = 1'b1;
        // Counter frozen while any hold keeps the front end still.
        if (!w_hold_all && !w_hold_bus) begin
          if (r_flush_cnt <= 2'd1) begin
            w_state_next     = ST_RUN;
            w_flush_cnt_next = 2'd0;
          end else begin
            w_flush_cnt_next = r_flush_cnt - 2'd1;
          end
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase

    // An accepted jump restarts the redirect sequence from any state.
    if (w_jump_acc) begin
      if (w_hold_bus) begin
        w_latch_en    = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        pc_load_o     = 1'b0;
        w_state_next  = ST_REDIRECT;
      end else begin
        pc_load_o        = 1'b1;
        pc_load_addr_o   = jump_addr_i;
        flush_if_id_o    = 1'b1;
        flush_id_ex_o    = 1'b1;
        w_state_next     = LOAD_NEXT;
        w_flush_cnt_next = FLUSH_INIT;
      end
    end

    // In reset the pipe registers are kept flushed and nothing moves the PC.
    if (!rst_) begin
      hold_pc_o      = 1'b0;
      hold_if_id_o   = 1'b0;
      hold_id_ex_o   = 1'b0;
      flush_if_id_o  = 1'b1;
      flush_id_ex_o  = 1'b1;
      pc_load_o      = 1'b0;
      pc_load_addr_o = '0;
      w_latch_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_stall_cnt <= '0;
    end else if (hold_pc_o && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign state_o     = r_state;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Two instances share the input stimulus:
//   dut1 - defaults (FLUSH_CYCLES=1, STALL_CNT_W=16)
//   dut3 - FLUSH_CYCLES=3, STALL_CNT_W=4
// ctl = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, pc_load}
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        irq;
  logic        ex;
  logic        bus;

  logic        hold_pc1, hold_if1, hold_ex1, flush_if1, flush_ex1, pc_load1;
  logic [31:0] addr1;
  logic [1:0]  state1;
  logic [15:0] cnt1;
  logic        hold_pc3, hold_if3, hold_ex3, flush_if3, flush_ex3, pc_load3;
  logic [31:0] addr3;
  logic [1:0]  state3;
  logic [3:0]  cnt3;

  logic [5:0]  ctl1;
  logic [5:0]  ctl3;
  assign ctl1 = {hold_pc1, hold_if1, hold_ex1, flush_if1, flush_ex1, pc_load1};
  assign ctl3 = {hold_pc3, hold_if3, hold_ex3, flush_if3, flush_ex3, pc_load3};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut1 (
    .clk            (clk),
    .rst_           (rst_),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .hold_irq_req_i (irq),
    .hold_ex_req_i  (ex),
    .hold_bus_req_i (bus),
    .hold_pc_o      (hold_pc1),
    .hold_if_id_o   (hold_if1),
    .hold_id_ex_o   (hold_ex1),
    .flush_if_id_o  (flush_if1),
    .flush_id_ex_o  (flush_ex1),
    .pc_load_o      (pc_load1),
    .pc_load_addr_o (addr1),
    .state_o        (state1),
    .stall_cnt_o    (cnt1)
  );

  pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .STALL_CNT_W  (4)
  ) dut3 (
    .clk            (clk),
    .rst_           (rst_),
    .jump_req_i     (jump_req),
    .jump_addr_i    (jump_addr),
    .hold_irq_req_i (irq),
    .hold_ex_req_i  (ex),
    .hold_bus_req_i (bus),
    .hold_pc_o      (hold_pc3),
    .hold_if_id_o   (hold_if3),
    .hold_id_ex_o   (hold_ex3),
    .flush_if_id_o  (flush_if3),
    .flush_id_ex_o  (flush_ex3),
    .pc_load_o      (pc_load3),
    .pc_load_addr_o (addr3),
    .state_o        (state3),
    .stall_cnt_o    (cnt3)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic j, input logic [31:0] a, input logic i_irq,
                       input logic i_ex, input logic i_bus);
    jump_req  = j;
    jump_addr = a;
    irq       = i_irq;
    ex        = i_ex;
    bus       = i_bus;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    drive(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000110) begin tests_failed++; $display("FAIL reset_ctl1 got %b exp %b", ctl1, 6'b000110); end
    tests_run++; if (ctl3 !== 6'b000110) begin tests_failed++; $display("FAIL reset_ctl3 got %b exp %b", ctl3, 6'b000110); end
    tests_run++; if (addr1 !== 32'h0) begin tests_failed++; $display("FAIL reset_addr got %h exp %h", addr1, 32'h0); end
    tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", state1); end
    tests_run++; if (cnt1 !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d exp 0", cnt1); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000000) begin tests_failed++; $display("FAIL idle_ctl got %b exp %b", ctl1, 6'b000000); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic_jump();
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000111) begin tests_failed++; $display("FAIL jump_ctl got %b exp %b", ctl1, 6'b000111); end
    tests_run++; if (addr1 !== 32'h100) begin tests_failed++; $display("FAIL jump_addr got %h exp %h", addr1, 32'h100); end
    next_cycle();
    drive(1'b0, 32'h3C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000000) begin tests_failed++; $display("FAIL jump_after_ctl got %b exp %b", ctl1, 6'b000000); end
    tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("FAIL jump_after_state got %0d exp 0", state1); end
    tests_run++; if (addr1 !== 32'h3C) begin tests_failed++; $display("FAIL run_addr_pass got %h exp %h", addr1, 32'h3C); end
    $display("[TB] test_basic_jump done");
  endtask

  task automatic test_redirect_bus();
    next_cycle();
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b110110) begin tests_failed++; $display("FAIL redir_c1_ctl got %b exp %b", ctl1, 6'b110110); end
    for (int c = 2; c <= 3; c++) begin
      next_cycle();
      drive(1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      tests_run++; if (state1 !== 2'd1) begin tests_failed++; $display("FAIL redir_c%0d_state got %0d exp 1", c, state1); end
      tests_run++; if (ctl1 !== 6'b110110) begin tests_failed++; $display("FAIL redir_c%0d_ctl got %b exp %b", c, ctl1, 6'b110110); end
    end
    next_cycle();
    drive(1'b0, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000111) begin tests_failed++; $display("FAIL redir_c4_ctl got %b exp %b", ctl1, 6'b000111); end
    tests_run++; if (addr1 !== 32'h200) begin tests_failed++; $display("FAIL redir_c4_addr got %h exp %h", addr1, 32'h200); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("FAIL redir_c5_state got %0d exp 0", state1); end
    tests_run++; if (ctl1 !== 6'b000000) begin tests_failed++; $display("FAIL redir_c5_ctl got %b exp %b", ctl1, 6'b000000); end
    tests_run++; if (cnt1 !== 16'd3) begin tests_failed++; $display("FAIL redir_stall_cnt got %0d exp 3", cnt1); end
    $display("[TB] test_redirect_bus done");
  endtask

  task automatic test_ex_hold();
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b111000) begin tests_failed++; $display("FAIL exhold_ctl got %b exp %b", ctl1, 6'b111000); end
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000111) begin tests_failed++; $display("FAIL exrel_ctl got %b exp %b", ctl1, 6'b000111); end
    tests_run++; if (addr1 !== 32'h300) begin tests_failed++; $display("FAIL exrel_addr got %h exp %h", addr1, 32'h300); end
    $display("[TB] test_ex_hold done");
  endtask

  task automatic test_irq_priority();
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b111000) begin tests_failed++; $display("FAIL irq_bus_ctl got %b exp %b", ctl1, 6'b111000); end
    next_cycle();
    @(negedge clk);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b110010) begin tests_failed++; $display("FAIL bus_only_ctl got %b exp %b", ctl1, 6'b110010); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (cnt1 !== 16'd7) begin tests_failed++; $display("FAIL irq_stall_cnt got %0d exp 7", cnt1); end
    $display("[TB] test_irq_priority done");
  endtask

  task automatic test_redirect_irq();
    next_cycle();
    drive(1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    next_cycle();
    drive(1'b1, 32'h777, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b111100) begin tests_failed++; $display("FAIL redir_irq_ctl got %b exp %b", ctl1, 6'b111100); end
    tests_run++; if (state1 !== 2'd1) begin tests_failed++; $display("FAIL redir_irq_state got %0d exp 1", state1); end
    next_cycle();
    drive(1'b0, 32'h777, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000111) begin tests_failed++; $display("FAIL redir_irq_load got %b exp %b", ctl1, 6'b000111); end
    tests_run++; if (addr1 !== 32'h600) begin tests_failed++; $display("FAIL redir_irq_addr got %h exp %h", addr1, 32'h600); end
    $display("[TB] test_redirect_irq done");
  endtask

  task automatic test_flush_restart();
    // Park dut1 in REDIRECT, then reset it mid-sequence.
    next_cycle();
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst_ = 1'b0;
    @(negedge clk);
    tests_run++; if (state1 !== 2'd0) begin tests_failed++; $display("FAIL midrst_state got %0d exp 0", state1); end
    tests_run++; if (ctl1 !== 6'b000110) begin tests_failed++; $display("FAIL midrst_ctl got %b exp %b", ctl1, 6'b000110); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;
    @(negedge clk);
    tests_run++; if (ctl1 !== 6'b000000) begin tests_failed++; $display("FAIL midrst_rel_ctl got %b exp %b", ctl1, 6'b000000); end
    tests_run++; if (cnt3 !== 4'd0) begin tests_failed++; $display("FAIL midrst_cnt3 got %0d exp 0", cnt3); end
    // Two back-to-back jumps on the FLUSH_CYCLES=3 instance.
    next_cycle();
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (ctl3 !== 6'b000111) begin tests_failed++; $display("FAIL fl3_j1_ctl got %b exp %b", ctl3, 6'b000111); end
    next_cycle();
    drive(1'b1, 32'h480, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (state3 !== 2'd2) begin tests_failed++; $display("FAIL fl3_j2_state got %0d exp 2", state3); end
    tests_run++; if (ctl3 !== 6'b000111) begin tests_failed++; $display("FAIL fl3_j2_ctl got %b exp %b", ctl3, 6'b000111); end
    tests_run++; if (addr3 !== 32'h480) begin tests_failed++; $display("FAIL fl3_j2_addr got %h exp %h", addr3, 32'h480); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      tests_run++; if (state3 !== 2'd2) begin tests_failed++; $display("FAIL fl3_f%0d_state got %0d exp 2", c, state3); end
      tests_run++; if (ctl3 !== 6'b000100) begin tests_failed++; $display("FAIL fl3_f%0d_ctl got %b exp %b", c, ctl3, 6'b000100); end
    end
    next_cycle();
    @(negedge clk);
    tests_run++; if (state3 !== 2'd0) begin tests_failed++; $display("FAIL fl3_end_state got %0d exp 0", state3); end
    tests_run++; if (ctl3 !== 6'b000000) begin tests_failed++; $display("FAIL fl3_end_ctl got %b exp %b", ctl3, 6'b000000); end
    $display("[TB] test_flush_restart done");
  endtask

  task automatic test_stall_saturation();
    for (int c = 0; c < 14; c++) begin
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (cnt3 !== 4'd14) begin tests_failed++; $display("FAIL sat_cnt3_14 got %0d exp 14", cnt3); end
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++; if (cnt3 !== 4'd15) begin tests_failed++; $display("FAIL sat_cnt3_20 got %0d exp 15", cnt3); end
    tests_run++; if (cnt1 !== 16'd20) begin tests_failed++; $display("FAIL sat_cnt1_20 got %0d exp 20", cnt1); end
    $display("[TB] test_stall_saturation done");
  endtask

  initial begin
    test_reset();
    test_basic_jump();
    test_redirect_bus();
    test_ex_hold();
    test_irq_priority();
    test_redirect_irq();
    test_flush_restart();
    test_stall_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
